// File: rtl/pcb_uart_pkg.sv
// Shared definitions for the PCB control FPGA UART transmitter and receiver.
package pcb_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int   DEFAULT_CLKS_PER_BIT = 868;
    localparam logic UART_IDLE_LEVEL      = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high and flags the
// last cycle of each period (bit_tick) and the cycle just before it (bit_tick_next).
module uart_baud_gen
    import pcb_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bit_tick,
    output logic bit_tick_next
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PREV = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_r;

    // Period counter; held at zero while idle so each frame starts phase-aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (!run) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign bit_tick      = run && (cnt_r == CNT_LAST);
    assign bit_tick_next = run && (cnt_r == CNT_PREV);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, LSB first, idle-high line, with a one-deep holding register
// so a queued byte follows the previous stop bit without an idle gap.
module uart_tx
    import pcb_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data_in,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_overrun,
    output logic       tx_serial_out
);

    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [0:0] STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_t  state_r, state_s;
    logic [7:0] shift_r, shift_s;
    logic [7:0] hold_r, hold_s;
    logic [2:0] idx_r, idx_s;
    logic [0:0] stop_r, stop_s;
    logic       line_r, line_s;
    logic       busy_r, busy_s;
    logic       ready_r, ready_s;
    logic       done_r, done_s;
    logic       ovr_r, ovr_s;

    logic       bit_tick_s;
    logic       bit_tick_next_s;
    logic       accept_s;
    logic       last_stop_s;
    logic       final_s;
    logic [2:0] idx_inc_s;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk           (clk),
        .reset         (reset),
        .run           (busy_r),
        .bit_tick      (bit_tick_s),
        .bit_tick_next (bit_tick_next_s)
    );

    assign accept_s    = tx_start && ready_r;
    assign last_stop_s = (state_r == STOP) && (stop_r == STOP_LAST);
    assign final_s     = last_stop_s && bit_tick_s;
    assign idx_inc_s   = idx_r + 3'd1;

    // Next-state and next-output decode; outputs are registered from these values.
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        hold_s  = hold_r;
        idx_s   = idx_r;
        stop_s  = stop_r;
        line_s  = line_r;
        busy_s  = busy_r;
        ready_s = ready_r;
        // done is armed one cycle early so the registered pulse lands on the final stop cycle
        done_s  = last_stop_s && bit_tick_next_s;
        ovr_s   = tx_start && !ready_r;

        case (state_r)
            IDLE: begin
                line_s = UART_IDLE_LEVEL;
                if (accept_s) begin
                    state_s = START;
                    shift_s = tx_data_in;
                    line_s  = ~UART_IDLE_LEVEL;
                    busy_s  = 1'b1;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            START: begin
                if (bit_tick_s) begin
                    state_s = DATA;
                    idx_s   = 3'd0;
                    line_s  = shift_r[0];
                end else begin
                    line_s  = ~UART_IDLE_LEVEL;
                end
            end
            DATA: begin
                if (bit_tick_s) begin
                    if (idx_r == DATA_LAST) begin
                        state_s = STOP;
                        stop_s  = 1'b0;
                        line_s  = UART_IDLE_LEVEL;
                    end else begin
                        idx_s   = idx_inc_s;
                        line_s  = shift_r[idx_inc_s];
                    end
                end else begin
                    line_s = shift_r[idx_r];
                end
            end
            STOP: begin
                if (bit_tick_s) begin
                    if (stop_r == STOP_LAST) begin
                        if (!ready_r) begin
                            state_s = START;
                            shift_s = hold_r;
                            ready_s = 1'b1;
                            line_s  = ~UART_IDLE_LEVEL;
                        end else if (tx_start) begin
                            state_s = START;
                            shift_s = tx_data_in;
                            line_s  = ~UART_IDLE_LEVEL;
                        end else begin
                            state_s = IDLE;
                            busy_s  = 1'b0;
                            line_s  = UART_IDLE_LEVEL;
                        end
                    end else begin
                        stop_s = stop_r + 1'b1;
                        line_s = UART_IDLE_LEVEL;
                    end
                end else begin
                    line_s = UART_IDLE_LEVEL;
                end
            end
            default: begin
                state_s = IDLE;
                line_s  = UART_IDLE_LEVEL;
                busy_s  = 1'b0;
                ready_s = 1'b1;
            end
        endcase

        // A request mid-frame parks in the holding register, except on the final
        // stop cycle where it goes straight into the shifter instead.
        if (busy_r && accept_s && !final_s) begin
            hold_s  = tx_data_in;
            ready_s = 1'b0;
        end else begin
            hold_s  = hold_s;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            shift_r <= 8'h00;
            hold_r  <= 8'h00;
            idx_r   <= 3'd0;
            stop_r  <= 1'b0;
            line_r  <= UART_IDLE_LEVEL;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            hold_r  <= hold_s;
            idx_r   <= idx_s;
            stop_r  <= stop_s;
            line_r  <= line_s;
            busy_r  <= busy_s;
            ready_r <= ready_s;
            done_r  <= done_s;
            ovr_r   <= ovr_s;
        end
    end

    assign tx_serial_out = line_r;
    assign tx_busy       = busy_r;
    assign tx_ready      = ready_r;
    assign tx_done       = done_r;
    assign tx_overrun    = ovr_r;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter for the PCB control FPGA. It is the PC-bound counterpart of the UART receiver that feeds the rx_done/rx_data_out byte stream into the row/column shift-register state machine.
- Sends echo, acknowledge and status bytes back to the PC. Frame format: 8N1 by default, LSB first, idle-high line.
- A one-deep holding register allows back-to-back frames with no idle gap.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200 baud); must be >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5-8.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  in  1  system clock (same domain as clk1 of the control state machine).
- reset  in  1  synchronous, active-high reset.
- tx_start  in  1  one-cycle request; accepted only when tx_ready=1.
- tx_data_in  in  8  byte to send, sampled on the accepting edge; bits above DATA_BITS-1 are ignored.
- tx_ready  out  1  holding register empty; a request can be accepted this cycle.
- tx_busy  out  1  a frame is on the line (START, DATA or STOP).
- tx_done  out  1  one-cycle pulse on the last cycle of each frame's final stop bit.
- tx_overrun  out  1  one-cycle pulse when tx_start arrives while tx_ready=0.
- tx_serial_out  out  1  serial line, registered, idle high.

Behaviour:
- Reset values: tx_serial_out=1, tx_ready=1, tx_busy=0, tx_done=0, tx_overrun=0. State is IDLE and the holding register is empty.
- All outputs are registered. Reset asserted mid-frame aborts the frame; on the next edge the line is high and all flags are at reset values.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - line=1.
  - tx_start is accepted directly into the shifter; on the same edge the state becomes START, line=0, tx_busy=1.
  - Latency from the accepting edge to the start bit: the start bit is visible after that edge (1 cycle).
- START: held for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - Sends bit[idx], LSB first, for CLKS_PER_BIT cycles each.
  - After bit DATA_BITS-1, go to STOP.
- STOP:
  - line=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - tx_done pulses on the final cycle of STOP.
  - If the holding register is full at that point: go directly to START with the held byte (no idle cycle) and set tx_ready=1.
  - Otherwise go to IDLE with tx_busy=0.
- Holding register:
  - While tx_busy=1 and tx_ready=1, tx_start loads the holding register and clears tx_ready on the next edge.
  - When tx_start coincides with the final STOP cycle and the holding register is empty, the byte is loaded straight into the shifter. START follows with no gap and tx_ready stays 1.
- Overrun: tx_start with tx_ready=0 is dropped. tx_overrun pulses on the next edge; the holding and shifter contents are unchanged.
- Counters:
  - Bit-period counter width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, wraps to 0 and emits a bit tick.
  - Bit index counter width is 3.
  - Stop counter counts bit ticks up to STOP_BITS-1.
- Frame length: (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles.
- tx_data_in changing after acceptance has no effect on the frame.

Decomposition:
- Shared package pcb_uart_pkg holds:
  - the tx_state_t enum {IDLE, START, DATA, STOP};
  - DEFAULT_CLKS_PER_BIT = 868;
  - UART_IDLE_LEVEL = 1'b1.
  The receiver reuses this package.
- One sub-module, uart_baud_gen:
  - Interface: clk, reset, run, bit_tick.
  - The counter is cleared while run=0 so every frame starts phase-aligned.

Test Plan:
All scenarios use CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 unless noted, giving a 40-cycle frame.
1. Single byte: tx_start with 0xA5 from IDLE -> line sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. tx_busy is high for 40 cycles; tx_done pulses once at cycle 40; the line is high afterwards.
2. Back-to-back: 0x3C accepted, then 0xC3 at cycle 5 -> tx_ready=0 from cycle 6 until cycle 40. The second start bit begins at cycle 41 with no idle gap. tx_done pulses at cycles 40 and 80.
3. Overrun: 0x11 sent, then 0x22 accepted into holding, then 0x33 requested at cycle 10 -> tx_overrun pulses at cycle 11. Only 0x11 and 0x22 appear on the line.
4. Reset mid-frame: reset asserted at cycle 15 of sending 0xFF -> at cycle 16 the line is 1, tx_busy=0, tx_ready=1. A new 0x01 sent afterwards produces a correct frame.
5. STOP_BITS=2 and 0x00 -> start plus eight data bits are low for 36 cycles, the stop is high for 8 cycles, and tx_done pulses at cycle 44.
6. Loopback through the UART receiver: send col=0x07 then row=0x1D -> the receiver yields rx_data_out 0x07 and 0x1D with two rx_done pulses. No framing errors at CLKS_PER_BIT=868.
